alu_sequencer: RTL and testbench

Initiator side of the ALU interface. It accepts an operation request with a valid/ready handshake, decodes ALUOp/funct into the ALU's 4-bit control code, and drives the ALU operand and control inputs. It captures the ALU result and zero flag into a held response. MULTU is built by iterating the ALU's add code through a 32-step shift-add. The block sits between the multi-cycle control path and the combinational ALU.

---
 rtl/alu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Initiator side of the ALU interface: decodes a request into an ALU control code,
// drives the ALU for one cycle (or 32 shift-add steps for MULTU) and holds the response.
module alu_sequencer #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [31:0] resp_hi,
    output logic        resp_zero,
    output logic        resp_err,
    output logic [31:0] alu_r1,
    output logic [31:0] alu_r2,
    output logic [3:0]  alu_controle,
    input  logic [31:0] alu_rst,
    input  logic        alu_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_ILL = 4'b1111;

    logic [1:0]  state;
    logic [31:0] a_q, b_q;
    logic [3:0]  code_q;
    logic        err_q;
    logic [31:0] p_hi, p_lo;
    logic [4:0]  cnt;

    logic [3:0]  dec_code;
    logic        dec_err;
    logic        dec_mul;

    logic        carry;
    logic [31:0] nxt_hi, nxt_lo;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_DONE);

    always_comb begin
        dec_code = C_ILL;
        dec_err  = 1'b1;
        dec_mul  = 1'b0;
        case (alu_op)
            2'b00: begin dec_code = C_ADD; dec_err = 1'b0; end
            2'b01: begin dec_code = C_SUB; dec_err = 1'b0; end
            2'b10: begin
                case (funct)
                    6'b100100: begin dec_code = C_AND; dec_err = 1'b0; end
                    6'b100101: begin dec_code = C_OR;  dec_err = 1'b0; end
                    6'b100000: begin dec_code = C_ADD; dec_err = 1'b0; end
                    6'b100010: begin dec_code = C_SUB; dec_err = 1'b0; end
                    6'b101010: begin dec_code = C_SLT; dec_err = 1'b0; end
                    6'b100111: begin dec_code = C_NOR; dec_err = 1'b0; end
                    6'b011001: begin
                        if (MUL_EN) begin
                            dec_code = C_ADD;
                            dec_err  = 1'b0;
                            dec_mul  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // One shift-add step: the ALU adds the partial high word; the adder carry
    // is recovered by an unsigned wrap test and shifted in at the top.
    assign carry  = (alu_rst < p_hi);
    assign nxt_hi = {carry, alu_rst[31:1]};
    assign nxt_lo = {alu_rst[0], p_lo[31:1]};

    always_comb begin
        alu_r1       = 32'd0;
        alu_r2       = 32'd0;
        alu_controle = C_AND;
        case (state)
            S_EXEC: begin
                alu_r1       = a_q;
                alu_r2       = b_q;
                alu_controle = code_q;
            end
            S_MUL: begin
                alu_r1       = p_hi;
                alu_r2       = p_lo[0] ? a_q : 32'd0;
                alu_controle = C_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            code_q      <= C_AND;
            err_q       <= 1'b0;
            p_hi        <= 32'd0;
            p_lo        <= 32'd0;
            cnt         <= 5'd0;
            resp_result <= 32'd0;
            resp_hi     <= 32'd0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        code_q <= dec_code;
                        err_q  <= dec_err;
                        p_hi   <= 32'd0;
                        p_lo   <= op_b;
                        cnt    <= 5'd0;
                        state  <= dec_mul ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_result <= alu_rst;
                    resp_zero   <= alu_zero;
                    resp_hi     <= 32'd0;
                    resp_err    <= err_q;
                    state       <= S_DONE;
                end
                S_MUL: begin
                    p_hi <= nxt_hi;
                    p_lo <= nxt_lo;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        resp_result <= nxt_lo;
                        resp_hi     <= nxt_hi;
                        resp_zero   <= ({nxt_hi, nxt_lo} == 64'd0);
                        resp_err    <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, transaction-level reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, resp_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;

    logic        req_ready0, resp_valid0, resp_zero0, resp_err0, alu_zero0;
    logic [31:0] resp_result0, resp_hi0, r1_0, r2_0, alu_rst0;
    logic [3:0]  ctl0;

    logic        req_ready1, resp_valid1, resp_zero1, resp_err1, alu_zero1;
    logic [31:0] resp_result1, resp_hi1, r1_1, r2_1, alu_rst1;
    logic [3:0]  ctl1;

    int nchk = 0;
    int npass = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return (x < y) ? 32'd1 : 32'd0;
            4'b1100: return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_rst0  = alu_f(ctl0, r1_0, r2_0);
    assign alu_zero0 = (r1_0 == r2_0);
    assign alu_rst1  = alu_f(ctl1, r1_1, r2_1);
    assign alu_zero1 = (r1_1 == r2_1);

    alu_sequencer #(.MUL_EN(1'b1)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_result(resp_result0),
        .resp_hi(resp_hi0), .resp_zero(resp_zero0), .resp_err(resp_err0),
        .alu_r1(r1_0), .alu_r2(r2_0), .alu_controle(ctl0),
        .alu_rst(alu_rst0), .alu_zero(alu_zero0)
    );

    alu_sequencer #(.MUL_EN(1'b0)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_result(resp_result1),
        .resp_hi(resp_hi1), .resp_zero(resp_zero1), .resp_err(resp_err1),
        .alu_r1(r1_1), .alu_r2(r2_1), .alu_controle(ctl1),
        .alu_rst(alu_rst1), .alu_zero(alu_zero1)
    );

    // Reference: what a request must produce, straight from the operation table.
    function automatic void spec_op(input logic [1:0] op, input logic [5:0] fn,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [31:0] hi,
                                    output logic z, output logic e, output logic mul,
                                    output logic [3:0] code);
        logic [63:0] prod;
        prod = 64'd0;
        r = 32'd0; hi = 32'd0; e = 1'b0; mul = 1'b0; code = 4'b1111; z = (a == b);
        case (op)
            2'b00: begin r = a + b; code = 4'b0010; end
            2'b01: begin r = a - b; code = 4'b0110; end
            2'b10: case (fn)
                6'b100100: begin r = a & b; code = 4'b0000; end
                6'b100101: begin r = a | b; code = 4'b0001; end
                6'b100000: begin r = a + b; code = 4'b0010; end
                6'b100010: begin r = a - b; code = 4'b0110; end
                6'b101010: begin r = (a < b) ? 32'd1 : 32'd0; code = 4'b0111; end
                6'b100111: begin r = ~(a | b); code = 4'b1100; end
                6'b011001: begin
                    prod = {32'd0, a} * {32'd0, b};
                    r = prod[31:0]; hi = prod[63:32]; z = (prod == 64'd0);
                    mul = 1'b1; code = 4'b0010;
                end
                default: e = 1'b1;
            endcase
            default: e = 1'b1;
        endcase
    endfunction

    int          m_rem;
    logic        m_valid, m_zero, m_err;
    logic [31:0] m_res, m_hi, m_a, m_b;
    logic [31:0] p_res, p_hi;
    logic        p_zero, p_err, p_mul;
    logic [3:0]  p_code;

    task automatic model_reset();
        m_rem = 0; m_valid = 1'b0; m_res = 32'd0; m_hi = 32'd0;
        m_zero = 1'b0; m_err = 1'b0; p_mul = 1'b0; p_code = 4'd0;
        m_a = 32'd0; m_b = 32'd0;
    endtask

    task automatic model_step();
        if (m_valid) begin
            if (resp_ready) m_valid = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_valid = 1'b1; m_res = p_res; m_hi = p_hi; m_zero = p_zero; m_err = p_err;
            end
        end else if (req_valid) begin
            spec_op(alu_op, funct, op_a, op_b, p_res, p_hi, p_zero, p_err, p_mul, p_code);
            m_a = op_a; m_b = op_b;
            m_rem = p_mul ? 32 : 1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic compare();
        chk("req_ready", 64'(req_ready0), 64'(!m_valid && m_rem == 0));
        chk("resp_valid", 64'(resp_valid0), 64'(m_valid));
        chk("resp_result", 64'(resp_result0), 64'(m_res));
        chk("resp_hi", 64'(resp_hi0), 64'(m_hi));
        chk("resp_zero", 64'(resp_zero0), 64'(m_zero));
        chk("resp_err", 64'(resp_err0), 64'(m_err));
        if (m_rem == 0) begin
            chk("alu_controle_idle", 64'(ctl0), 64'd0);
            chk("alu_r1_idle", 64'(r1_0), 64'd0);
            chk("alu_r2_idle", 64'(r2_0), 64'd0);
        end else if (p_mul) begin
            chk("alu_controle_mul", 64'(ctl0), 64'(4'b0010));
        end else begin
            chk("alu_controle_exec", 64'(ctl0), 64'(p_code));
            chk("alu_r1_exec", 64'(r1_0), 64'(m_a));
            chk("alu_r2_exec", 64'(r2_0), 64'(m_b));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
        alu_op = op; funct = fn; op_a = a; op_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid0 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        alu_op = 2'b00; funct = 6'd0; op_a = 32'd0; op_b = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare();
        chk("rst_req_ready", 64'(req_ready0), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid0), 64'd0);
        chk("rst_controle", 64'(ctl0), 64'd0);
        reset = 1'b0;
        tick();

        run(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd2, lat);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_result", 64'(resp_result0), 64'h1);
        chk("add_zero", 64'(resp_zero0), 64'd0);
        chk("add_hi", 64'(resp_hi0), 64'd0);
        accept();

        run(2'b01, 6'd0, 32'h1234, 32'h1234, lat);
        chk("sub_result", 64'(resp_result0), 64'd0);
        chk("sub_zero", 64'(resp_zero0), 64'd1);
        accept();

        run(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, lat);
        chk("slt_unsigned_big", 64'(resp_result0), 64'd0);
        accept();
        run(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, lat);
        chk("slt_unsigned_small", 64'(resp_result0), 64'd1);
        accept();

        run(2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
        chk("and_result", 64'(resp_result0), 64'h00F0_1200);
        accept();
        run(2'b10, 6'b100111, 32'hF0F0_0000, 32'h0000_000F, lat);
        chk("nor_result", 64'(resp_result0), 64'h0F0F_FFF0);
        accept();
        run(2'b10, 6'b100101, 32'h1, 32'h8000_0000, lat);
        accept();
        run(2'b10, 6'b100010, 32'd3, 32'd5, lat);
        accept();

        run(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("mul_lat", 64'(lat), 64'd32);
        chk("mul_hi", 64'(resp_hi0), 64'hFFFF_FFFE);
        chk("mul_lo", 64'(resp_result0), 64'h1);
        chk("nomul_valid", 64'(resp_valid1), 64'd1);
        chk("nomul_err", 64'(resp_err1), 64'd1);
        chk("nomul_result", 64'(resp_result1), 64'd0);
        accept();

        run(2'b10, 6'b011001, 32'd0, 32'd5, lat);
        chk("mul0_hi", 64'(resp_hi0), 64'd0);
        chk("mul0_lo", 64'(resp_result0), 64'd0);
        chk("mul0_zero", 64'(resp_zero0), 64'd1);
        accept();
        run(2'b10, 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0, lat);
        accept();

        run(2'b11, 6'b100000, 32'd9, 32'd4, lat);
        chk("ill_lat", 64'(lat), 64'd1);
        chk("ill_result", 64'(resp_result0), 64'd0);
        chk("ill_err", 64'(resp_err0), 64'd1);
        accept();
        run(2'b10, 6'b111111, 32'd9, 32'd4, lat);
        chk("badfunct_err", 64'(resp_err0), 64'd1);
        accept();

        // Backpressure: response must hold while a new request waits.
        run(2'b00, 6'd0, 32'd5, 32'd6, lat);
        alu_op = 2'b01; op_a = 32'd9; op_b = 32'd4; req_valid = 1'b1;
        repeat (5) tick();
        chk("stall_result", 64'(resp_result0), 64'd11);
        chk("stall_ready", 64'(req_ready0), 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("release_idle", 64'(req_ready0), 64'd1);
        tick();
        chk("accept_next", 64'(req_ready0), 64'd0);
        req_valid = 1'b0;
        tick();
        chk("next_result", 64'(resp_result0), 64'd5);
        accept();

        // Reset in the middle of a multiply drops it.
        alu_op = 2'b10; funct = 6'b011001; op_a = 32'd7; op_b = 32'd9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        model_reset();
        compare();
        chk("midrst_valid", 64'(resp_valid0), 64'd0);
        chk("midrst_ready", 64'(req_ready0), 64'd1);
        chk("midrst_controle", 64'(ctl0), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        run(2'b00, 6'd0, 32'd3, 32'd4, lat);
        chk("post_rst_add", 64'(resp_result0), 64'd7);
        accept();
        tick();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
